elevator_car_ctrl: RTL and testbench
====================================

Name: elevator_car_ctrl

Overview:
- Car-side responder for the elevator floor-request path.
- Accepts a one-hot target floor from the request encoder over a valid/ready handshake.
- Moves the car one floor per travel interval, opens the door for a dwell interval on arrival, then returns to accepting requests.
- Sits between the switch-to-floor encoder and the floor/door indicator outputs.

Parameters:
- NUM_FLOORS, 4, number of floors; width of all one-hot floor buses.
- TICK_DIV, 16777216, clk cycles per timing tick.
- TRAVEL_TICKS, 1, ticks to travel between adjacent floors.
- DOOR_TICKS, 2, ticks the door stays open.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator has a target floor.
- req_floor  in  NUM_FLOORS  one-hot target floor; bit 0 = ground.
- req_ready  out  1  car can accept a request.
- cur_floor  out  NUM_FLOORS  one-hot current floor.
- moving_up  out  1  car travelling up.
- moving_down  out  1  car travelling down.
- door_open  out  1  door open.
- arrived  out  1  one-cycle pulse on reaching the target.
- req_err  out  1  one-cycle pulse when an accepted request is not one-hot.
- busy  out  1  state is not IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All outputs are registered.
- Reset values:
  - state = IDLE, cur_floor = 1 (ground), target = 0, prescaler = 0.
  - req_ready = 1.
  - moving_up, moving_down, door_open, arrived, req_err, busy = 0.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- Handshake:
  - Transfer happens on a clk edge with req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - The initiator holds req_valid and req_floor stable until transfer.
  - req_floor is sampled only at transfer.
- IDLE, on transfer:
  - req_floor is not one-hot (zero or more than one bit set): req_err pulses the next cycle, state stays IDLE, no movement.
  - req_floor == cur_floor: go to DOOR_OPEN; arrived pulses in the first DOOR_OPEN cycle.
  - req_floor > cur_floor (unsigned compare): go to MOVE_UP and latch target.
  - req_floor < cur_floor: go to MOVE_DOWN and latch target.
- Timing base:
  - The prescaler (0..TICK_DIV-1) is cleared on every transfer and on every entry to DOOR_OPEN.
  - A tick is emitted when the prescaler wraps.
  - The tick counter is cleared together with the prescaler.
- MOVE_UP / MOVE_DOWN:
  - After TRAVEL_TICKS ticks, cur_floor shifts left (up) or right (down) by one bit and the tick counter restarts.
  - Exactly TICK_DIV*TRAVEL_TICKS cycles separate consecutive floor changes. The first change comes that many cycles after the transfer edge.
  - When the shifted value equals target, go to DOOR_OPEN in the same edge.
  - moving_up / moving_down are high throughout their move state and go low on DOOR_OPEN entry.
- Saturation: cur_floor never shifts past bit NUM_FLOORS-1 or below bit 0. If a shift would overflow or underflow, hold the value and go to DOOR_OPEN (defensive; unreachable with valid targets).
- DOOR_OPEN:
  - door_open = 1.
  - arrived = 1 in the first cycle only.
  - After DOOR_TICKS ticks (TICK_DIV*DOOR_TICKS cycles after entry), go to IDLE with door_open = 0 and req_ready = 1 on the same edge.
- Invariants: cur_floor is always exactly one-hot; moving_up, moving_down and door_open are mutually exclusive.
- Reset mid-operation: every register returns to its reset value immediately and asynchronously; any in-flight target is discarded.

Optional Feature:
- Macro: ELEVATOR_ESTOP_EN.
- Defined: adds input port estop (1 bit, level).
  - While estop = 1: prescaler and tick counter freeze, cur_floor and state hold, req_ready = 0, moving_up/moving_down are forced to 0, door_open holds its current value.
  - On release, operation resumes with the remaining time intact.
  - estop takes priority over a simultaneous handshake; no transfer occurs.
- Not defined: no estop port; behaviour exactly as above.

Decomposition:
- Package elevator_pkg:
  - state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN).
  - default NUM_FLOORS.
  - GROUND_FLOOR one-hot constant.
  - a one-hot validity check function.
- Sub-module elevator_tick_gen (parameter TICK_DIV; ports clk, rst, clear, hold, tick) owns the prescaler.
- FSM and floor register live in the top.

Test Plan:
- Bench overrides TICK_DIV=4, TRAVEL_TICKS=2, DOOR_TICKS=3.
- Reset: assert rst mid-clock -> cur_floor=0001, req_ready=1, door_open=0, busy=0 immediately, without waiting for a clk edge.
- Up travel: from 0001 send 0100.
  - moving_up=1 from cycle 1.
  - cur_floor=0010 at cycle 8, 0100 at cycle 16.
  - arrived pulses at cycle 16, door_open high cycles 16-27, req_ready=1 at cycle 28.
- Down travel: from 1000 send 0001 -> moving_down=1; cur_floor 0100 at cycle 8, 0010 at 16, 0001 at 24; arrived at 24.
- Same floor: at 0010 send 0010 -> door_open and arrived at cycle 1, no moving_* assertion, IDLE after 12 cycles.
- Invalid and backpressure:
  - Send 0110 -> req_err pulses once, state stays IDLE, cur_floor unchanged.
  - req_valid held while busy -> req_ready=0 and no transfer until IDLE.
- Reset mid-travel: rst during MOVE_UP between 0010 and 0100 -> cur_floor=0001, moving_up=0, req_ready=1 asynchronously; the next request times from scratch.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_e;

  localparam int DEF_NUM_FLOORS = 4;
  localparam logic [31:0] GROUND_FLOOR = 32'd1;

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/elevator_tick_gen.sv
// Prescaler producing one tick every TICK_DIV clk cycles; clear restarts the count, hold freezes it.
module elevator_tick_gen #(
  parameter int TICK_DIV = 16777216
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          wrap_s;

  // tick must not depend on clear: the controller derives clear from tick.
  assign wrap_s = (cnt_q == PW'(TICK_DIV - 1));
  assign tick   = wrap_s && !hold;

  // Prescaler next value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: accepts one-hot floor requests, travels, dwells with door open.
// Optional emergency stop input enabled by defining ELEVATOR_ESTOP_EN.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int TICK_DIV     = 16777216,
  parameter int TRAVEL_TICKS = 1,
  parameter int DOOR_TICKS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic                  req_valid,
  input  logic [NUM_FLOORS-1:0] req_floor,
  output logic                  req_ready,
  output logic [NUM_FLOORS-1:0] cur_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  arrived,
  output logic                  req_err,
  output logic                  busy
);

  localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [NUM_FLOORS-1:0] GROUND = NUM_FLOORS'(GROUND_FLOOR);

  state_e                state_q, state_d;
  logic [NUM_FLOORS-1:0] cur_floor_q, cur_floor_d;
  logic [NUM_FLOORS-1:0] target_q, target_d;
  logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic req_ready_q, req_ready_d;
  logic moving_up_q, moving_up_d;
  logic moving_down_q, moving_down_d;
  logic door_open_q, door_open_d;
  logic arrived_q, arrived_d;
  logic req_err_q, req_err_d;
  logic busy_q, busy_d;

  logic                  hold_s;
  logic                  tick_s;
  logic                  clear_s;
  logic                  transfer_s;
  logic                  travel_done_s;
  logic                  door_done_s;
  logic [NUM_FLOORS-1:0] floor_up_s;
  logic [NUM_FLOORS-1:0] floor_dn_s;

`ifdef ELEVATOR_ESTOP_EN
  assign hold_s = estop;
`else
  assign hold_s = 1'b0;
`endif

  elevator_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .hold  (hold_s),
    .tick  (tick_s)
  );

  assign transfer_s    = req_valid && req_ready_q && !hold_s;
  assign travel_done_s = tick_s && (tick_cnt_q == CNT_W'(TRAVEL_TICKS - 1));
  assign door_done_s   = tick_s && (tick_cnt_q == CNT_W'(DOOR_TICKS - 1));
  assign floor_up_s    = cur_floor_q << 1;
  assign floor_dn_s    = cur_floor_q >> 1;

  // Next-state, floor/target and tick-counter logic; door entry always restarts timing.
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    target_d    = target_q;
    tick_cnt_d  = tick_cnt_q;
    clear_s     = 1'b0;
    arrived_d   = 1'b0;
    req_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (transfer_s) begin
          clear_s    = 1'b1;
          tick_cnt_d = '0;
          if (!is_one_hot(32'(req_floor))) begin
            req_err_d = 1'b1;
          end else if (req_floor == cur_floor_q) begin
            state_d   = ST_DOOR_OPEN;
            arrived_d = 1'b1;
          end else if (req_floor > cur_floor_q) begin
            state_d  = ST_MOVE_UP;
            target_d = req_floor;
          end else begin
            state_d  = ST_MOVE_DOWN;
            target_d = req_floor;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (hold_s) begin
          state_d = state_q;
        end else if (travel_done_s) begin
          tick_cnt_d = '0;
          if ((state_q == ST_MOVE_UP) ? cur_floor_q[NUM_FLOORS-1] : cur_floor_q[0]) begin
            state_d = ST_DOOR_OPEN;
            clear_s = 1'b1;
          end else begin
            cur_floor_d = (state_q == ST_MOVE_UP) ? floor_up_s : floor_dn_s;
            if (cur_floor_d == target_q) begin
              state_d   = ST_DOOR_OPEN;
              clear_s   = 1'b1;
              arrived_d = 1'b1;
            end else begin
              state_d = state_q;
            end
          end
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      ST_DOOR_OPEN: begin
        if (hold_s) begin
          state_d = ST_DOOR_OPEN;
        end else if (door_done_s) begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs derived from the next state.
  always_comb begin
    req_ready_d   = (state_d == ST_IDLE) && !hold_s;
    moving_up_d   = (state_d == ST_MOVE_UP) && !hold_s;
    moving_down_d = (state_d == ST_MOVE_DOWN) && !hold_s;
    door_open_d   = (state_d == ST_DOOR_OPEN);
    busy_d        = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_floor_q   <= GROUND;
      target_q      <= '0;
      tick_cnt_q    <= '0;
      req_ready_q   <= 1'b1;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_open_q   <= 1'b0;
      arrived_q     <= 1'b0;
      req_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_floor_q   <= cur_floor_d;
      target_q      <= target_d;
      tick_cnt_q    <= tick_cnt_d;
      req_ready_q   <= req_ready_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
      door_open_q   <= door_open_d;
      arrived_q     <= arrived_d;
      req_err_q     <= req_err_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign cur_floor   = cur_floor_q;
  assign moving_up   = moving_up_q;
  assign moving_down = moving_down_q;
  assign door_open   = door_open_q;
  assign arrived     = arrived_q;
  assign req_err     = req_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed self-checking bench for elevator_car_ctrl with TICK_DIV=4, TRAVEL_TICKS=2, DOOR_TICKS=3.
module tb_elevator_car_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_floor = 4'b0000;
  logic       req_ready;
  logic [3:0] cur_floor;
  logic       moving_up, moving_down, door_open, arrived, req_err, busy;

  int checks = 0;
  int errors = 0;

  elevator_car_ctrl #(
    .NUM_FLOORS   (4),
    .TICK_DIV     (4),
    .TRAVEL_TICKS (2),
    .DOOR_TICKS   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_floor   (req_floor),
    .req_ready   (req_ready),
    .cur_floor   (cur_floor),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open),
    .arrived     (arrived),
    .req_err     (req_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Present a request at a negedge; returns #1 after the transfer edge (edge 0).
  task automatic send(input logic [3:0] f, input bit keep);
    @(negedge clk);
    req_valid = 1'b1;
    req_floor = f;
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(req_ready === 1'b1 && busy === 1'b0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_idle: timeout req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({cur_floor, req_ready, door_open, busy} !== {4'b0001, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: cur=%b rdy=%b door=%b busy=%b required 0001 1 0 0",
               cur_floor, req_ready, door_open, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({moving_up, moving_down, arrived, req_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: up/dn/arr/err=%b required 0000",
               {moving_up, moving_down, arrived, req_err});
    end
  endtask

  task automatic test_up_travel();
    logic [3:0] exp_floor;
    send(4'b0100, 1'b0);
    checks++;
    if ({moving_up, req_ready, busy, cur_floor} !== {1'b1, 1'b0, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL up_start: up=%b rdy=%b busy=%b cur=%b required 1 0 1 0001",
               moving_up, req_ready, busy, cur_floor);
    end
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk);
      #1;
      exp_floor = (k < 8) ? 4'b0001 : (k < 16) ? 4'b0010 : 4'b0100;
      checks++;
      if ({cur_floor, moving_up, arrived, door_open, req_ready, busy} !==
          {exp_floor, k < 16, k == 16, (k >= 16 && k <= 27), k >= 28, k < 28}) begin
        errors++;
        $display("FAIL up_cycle%0d: cur=%b up=%b arr=%b door=%b rdy=%b busy=%b required cur=%b up=%b arr=%b door=%b rdy=%b busy=%b",
                 k, cur_floor, moving_up, arrived, door_open, req_ready, busy,
                 exp_floor, k < 16, k == 16, (k >= 16 && k <= 27), k >= 28, k < 28);
      end
    end
  endtask

  task automatic test_down_travel();
    logic [3:0] exp_floor;
    send(4'b1000, 1'b0);
    wait_idle();
    send(4'b0001, 1'b0);
    checks++;
    if ({moving_down, moving_up, cur_floor} !== {1'b1, 1'b0, 4'b1000}) begin
      errors++;
      $display("FAIL down_start: dn=%b up=%b cur=%b required 1 0 1000", moving_down, moving_up, cur_floor);
    end
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk);
      #1;
      exp_floor = (k < 8) ? 4'b1000 : (k < 16) ? 4'b0100 : (k < 24) ? 4'b0010 : 4'b0001;
      checks++;
      if ({cur_floor, moving_down, arrived, door_open, req_ready} !==
          {exp_floor, k < 24, k == 24, (k >= 24 && k <= 35), k >= 36}) begin
        errors++;
        $display("FAIL down_cycle%0d: cur=%b dn=%b arr=%b door=%b rdy=%b required cur=%b dn=%b arr=%b door=%b rdy=%b",
                 k, cur_floor, moving_down, arrived, door_open, req_ready,
                 exp_floor, k < 24, k == 24, (k >= 24 && k <= 35), k >= 36);
      end
    end
  endtask

  task automatic test_same_floor();
    send(4'b0010, 1'b0);
    wait_idle();
    send(4'b0010, 1'b0);
    checks++;
    if ({door_open, arrived, moving_up, moving_down, cur_floor} !== {4'b1100, 4'b0010}) begin
      errors++;
      $display("FAIL same_start: door=%b arr=%b up=%b dn=%b cur=%b required 1 1 0 0 0010",
               door_open, arrived, moving_up, moving_down, cur_floor);
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({door_open, arrived, moving_up, moving_down, req_ready} !== {k < 12, 3'b000, k >= 12}) begin
        errors++;
        $display("FAIL same_cycle%0d: door=%b arr=%b up=%b dn=%b rdy=%b required door=%b arr=0 up=0 dn=0 rdy=%b",
                 k, door_open, arrived, moving_up, moving_down, req_ready, k < 12, k >= 12);
      end
    end
  endtask

  task automatic test_invalid();
    logic [3:0] bad [2];
    bad[0] = 4'b0110;
    bad[1] = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      send(bad[i], 1'b0);
      checks++;
      if ({req_err, busy, req_ready, cur_floor, moving_up, moving_down} !== {3'b101, 4'b0010, 2'b00}) begin
        errors++;
        $display("FAIL invalid_%b: err=%b busy=%b rdy=%b cur=%b up=%b dn=%b required 1 0 1 0010 0 0",
                 bad[i], req_err, busy, req_ready, cur_floor, moving_up, moving_down);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({req_err, busy, cur_floor} !== {2'b00, 4'b0010}) begin
        errors++;
        $display("FAIL invalid_pulse_%b: err=%b busy=%b cur=%b required 0 0 0010",
                 bad[i], req_err, busy, cur_floor);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_floor;
    send(4'b1000, 1'b1);
    req_floor = 4'b0001;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk);
      #1;
      exp_floor = (k < 8) ? 4'b0010 : (k < 16) ? 4'b0100 : 4'b1000;
      checks++;
      if ({req_ready, cur_floor, moving_down} !== {k == 28, exp_floor, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_cycle%0d: rdy=%b cur=%b dn=%b required rdy=%b cur=%b dn=0",
                 k, req_ready, cur_floor, moving_down, k == 28, exp_floor);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if ({moving_down, req_ready, cur_floor} !== {2'b10, 4'b1000}) begin
      errors++;
      $display("FAIL backpressure_accept: dn=%b rdy=%b cur=%b required 1 0 1000", moving_down, req_ready, cur_floor);
    end
  endtask

  task automatic test_reset_mid_travel();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(4'b0100, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if ({cur_floor, moving_up} !== {4'b0010, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre: cur=%b up=%b required 0010 1", cur_floor, moving_up);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cur_floor, moving_up, req_ready, busy} !== {4'b0001, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: cur=%b up=%b rdy=%b busy=%b required 0001 0 1 0",
               cur_floor, moving_up, req_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    send(4'b0100, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({cur_floor, moving_up} !== {(k < 8) ? 4'b0001 : 4'b0010, 1'b1}) begin
        errors++;
        $display("FAIL mid_restart_cycle%0d: cur=%b up=%b required cur=%b up=1",
                 k, cur_floor, moving_up, (k < 8) ? 4'b0001 : 4'b0010);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_travel();
    test_down_travel();
    test_same_floor();
    test_invalid();
    test_back_to_back();
    test_reset_mid_travel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
